// File: rtl/apb_slave_regfile.sv
// ---------------------------------------------------------------------------
// apb_slave_regfile
//   APB completer holding DEPTH registers of DATA_W bits. Every transfer takes
//   a fixed WAIT_CYCLES wait states in the access phase before Pready. Addresses
//   at or above DEPTH complete with Pslverr.
//
// Ports
//   Pclk     in   bus clock, rising edge
//   Preset   in   synchronous active-high reset
//   Psel     in   completer select
//   Penable  in   access-phase indicator
//   Pwrite   in   1 = write, 0 = read (latched in setup)
//   Paddr    in   register address (latched in setup)
//   PWdata   in   write data (latched in setup)
//   PRdata   out  read data, non-zero only in a read completion cycle
//   Pready   out  completion cycle indicator
//   Pslverr  out  out-of-range address, asserted only with Pready
// ---------------------------------------------------------------------------
module apb_slave_regfile #(
   parameter int                ADDR_W      = 4,
   parameter int                DATA_W      = 8,
   parameter int                DEPTH       = 12,
   parameter int                WAIT_CYCLES = 2,
   parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
   input  logic              Pclk,
   input  logic              Preset,
   input  logic              Psel,
   input  logic              Penable,
   input  logic              Pwrite,
   input  logic [ADDR_W-1:0] Paddr,
   input  logic [DATA_W-1:0] PWdata,
   output logic [DATA_W-1:0] PRdata,
   output logic              Pready,
   output logic              Pslverr
);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t            state;
   logic [3:0]        cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic              write_q;
   logic [DATA_W-1:0] regs [DEPTH];

   logic in_range;
   logic done;

   // All outputs decode registered state only, so there is no input-to-output path.
   assign in_range = int'(addr_q) < DEPTH;
   assign done     = (state == ACCESS) && (cnt == 4'd0);

   assign Pready  = done;
   assign Pslverr = done && !in_range;
   assign PRdata  = (done && !write_q && in_range) ? regs[addr_q] : '0;

   always_ff @(posedge Pclk) begin
      if (Preset) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         addr_q  <= '0;
         data_q  <= '0;
         write_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) regs[i] <= RESET_VAL;
      end else begin
         case (state)
            IDLE: begin
               // Only a proper setup phase starts a transfer; a bare Penable is ignored.
               if (Psel && !Penable) begin
                  addr_q  <= Paddr;
                  data_q  <= PWdata;
                  write_q <= Pwrite;
                  cnt     <= 4'(WAIT_CYCLES);
                  state   <= ACCESS;
               end
            end
            ACCESS: begin
               if (!Psel) begin
                  state <= IDLE;          // master dropped the transfer: no commit
               end else if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  if (write_q && in_range) regs[addr_q] <= data_q;
                  state <= IDLE;          // next setup may arrive in the very next cycle
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// ---------------------------------------------------------------------------
// tb_apb_slave_regfile
//   Directed bench for apb_slave_regfile. Instance 0 uses WAIT_CYCLES=2,
//   instance 1 uses WAIT_CYCLES=0. Both share clock and reset; each has its
//   own bus. Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_apb_slave_regfile;

   logic       clk = 1'b0;
   logic       preset;
   logic       psel    [2];
   logic       penable [2];
   logic       pwrite  [2];
   logic [3:0] paddr   [2];
   logic [7:0] pwdata  [2];
   logic [7:0] prdata  [2];
   logic       pready  [2];
   logic       pslverr [2];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   apb_slave_regfile #(.WAIT_CYCLES(2)) u_dut (
      .Pclk(clk), .Preset(preset), .Psel(psel[0]), .Penable(penable[0]),
      .Pwrite(pwrite[0]), .Paddr(paddr[0]), .PWdata(pwdata[0]),
      .PRdata(prdata[0]), .Pready(pready[0]), .Pslverr(pslverr[0]));

   apb_slave_regfile #(.WAIT_CYCLES(0)) u_dut0 (
      .Pclk(clk), .Preset(preset), .Psel(psel[1]), .Penable(penable[1]),
      .Pwrite(pwrite[1]), .Paddr(paddr[1]), .PWdata(pwdata[1]),
      .PRdata(prdata[1]), .Pready(pready[1]), .Pslverr(pslverr[1]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One APB transfer. cyc counts setup plus access cycles up to and including
   // the completion cycle. Address/data are scrambled after setup to show the
   // completer uses its latched copy.
   task automatic xfer(input int w, input logic wr, input logic [3:0] a, input logic [7:0] d,
                       output logic [7:0] rd, output logic err, output int cyc, output logic seen);
      @(negedge clk);
      psel[w] = 1'b1; penable[w] = 1'b0; pwrite[w] = wr; paddr[w] = a; pwdata[w] = d;
      cyc = 1; seen = 1'b0; rd = '0; err = 1'b0;
      @(negedge clk);
      penable[w] = 1'b1; paddr[w] = ~a; pwdata[w] = ~d;
      for (int i = 0; i < 20 && !seen; i++) begin
         cyc++;
         if (pready[w]) begin
            seen = 1'b1; rd = prdata[w]; err = pslverr[w];
         end else begin
            @(negedge clk);
         end
      end
   endtask

   task automatic idle(input int w);
      @(negedge clk);
      psel[w] = 1'b0; penable[w] = 1'b0;
   endtask

   task automatic do_wr(input string tag, input int w, input logic [3:0] a, input logic [7:0] d,
                        input logic exp_err, input int exp_cyc);
      logic [7:0] rd; logic err; int cyc; logic seen;
      xfer(w, 1'b1, a, d, rd, err, cyc, seen);
      chk({tag, "_rdy"}, 32'(seen), 32'd1);
      chk({tag, "_err"}, 32'(err), 32'(exp_err));
      chk({tag, "_rdata0"}, 32'(rd), 32'h0);
      chk({tag, "_cyc"}, 32'(cyc), 32'(exp_cyc));
   endtask

   task automatic do_rd(input string tag, input int w, input logic [3:0] a, input logic [7:0] exp_d,
                        input logic exp_err, input int exp_cyc);
      logic [7:0] rd; logic err; int cyc; logic seen;
      xfer(w, 1'b0, a, 8'h00, rd, err, cyc, seen);
      chk({tag, "_rdy"}, 32'(seen), 32'd1);
      chk({tag, "_data"}, 32'(rd), 32'(exp_d));
      chk({tag, "_err"}, 32'(err), 32'(exp_err));
      chk({tag, "_cyc"}, 32'(cyc), 32'(exp_cyc));
   endtask

   initial begin
      logic any_rdy;
      preset = 1'b1;
      for (int w = 0; w < 2; w++) begin
         psel[w] = 1'b0; penable[w] = 1'b0; pwrite[w] = 1'b0; paddr[w] = '0; pwdata[w] = '0;
      end

      // Reset held 3 cycles; outputs quiet.
      repeat (3) @(negedge clk);
      for (int w = 0; w < 2; w++) begin
         chk($sformatf("rst_rdy%0d", w), 32'(pready[w]), 32'd0);
         chk($sformatf("rst_err%0d", w), 32'(pslverr[w]), 32'd0);
         chk($sformatf("rst_rdata%0d", w), 32'(prdata[w]), 32'h0);
      end
      preset = 1'b0;

      // 1: every implemented register reads reset value, 4-cycle transfers.
      for (int a = 0; a < 12; a++) do_rd($sformatf("t1_a%0d", a), 0, 4'(a), 8'h00, 1'b0, 4);
      idle(0);

      // 2: write then read back; Pready in T3 shows up as a 4-cycle count.
      do_wr("t2_wr", 0, 4'h5, 8'hA7, 1'b0, 4);
      do_rd("t2_rd", 0, 4'h5, 8'hA7, 1'b0, 4);
      idle(0);
      chk("t2_idle_rdy", 32'(pready[0]), 32'd0);

      // 3: out-of-range write and read error out, in-range contents untouched.
      do_wr("t3_wr_oor", 0, 4'hD, 8'h3C, 1'b1, 4);
      do_rd("t3_rd_oor", 0, 4'hE, 8'h00, 1'b1, 4);
      do_rd("t3_rd_5", 0, 4'h5, 8'hA7, 1'b0, 4);
      do_rd("t3_rd_1", 0, 4'h1, 8'h00, 1'b0, 4);

      // 4: back-to-back transfers, no idle cycles between them.
      do_wr("t4_wr0", 0, 4'h0, 8'h11, 1'b0, 4);
      do_wr("t4_wr1", 0, 4'h1, 8'h22, 1'b0, 4);
      do_rd("t4_rd0", 0, 4'h0, 8'h11, 1'b0, 4);
      do_rd("t4_rd1", 0, 4'h1, 8'h22, 1'b0, 4);
      do_wr("t4_wr3", 0, 4'h3, 8'h99, 1'b0, 4);
      do_rd("t4_rd3", 0, 4'h3, 8'h99, 1'b0, 4);
      idle(0);

      // 5: reset in T1 of a write aborts it; reset also clears earlier writes.
      @(negedge clk);
      psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 4'h3; pwdata[0] = 8'h55;
      @(negedge clk);
      penable[0] = 1'b1; preset = 1'b1;
      any_rdy = pready[0];
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         any_rdy |= pready[0];
         if (i == 1) begin preset = 1'b0; psel[0] = 1'b0; penable[0] = 1'b0; end
      end
      chk("t5_no_rdy", 32'(any_rdy), 32'd0);
      do_rd("t5_rd3", 0, 4'h3, 8'h00, 1'b0, 4);
      do_rd("t5_rd0", 0, 4'h0, 8'h00, 1'b0, 4);
      idle(0);

      // 6: zero-wait instance completes in T1.
      do_wr("t6_wr", 1, 4'hB, 8'hF0, 1'b0, 2);
      do_rd("t6_rd", 1, 4'hB, 8'hF0, 1'b0, 2);
      do_rd("t6_oor", 1, 4'hC, 8'h00, 1'b1, 2);
      idle(1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
